// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg
//   Shared constants for the single-port synchronous RAM.
//   DEFAULT_DATA_WIDTH : default word width in bits
//   DEFAULT_ADDR_WIDTH : default address width in bits
//   depth_of()         : number of words addressable by a given address width
package sync_ram_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/sync_ram_word.sv
// sync_ram_word
//   One storage word of the RAM: a DATA_WIDTH register with write enable,
//   cleared by the asynchronous active-low reset.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_we    : load i_din on this edge
//   i_din   : write data
//   o_q     : stored word
module sync_ram_word #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_din;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_ram.sv
// sync_ram
//   Single-port synchronous RAM, flop based, 2**ADDR_WIDTH words, cleared by
//   reset. One address serves both read and write; read data is registered
//   (1-cycle latency) and read-during-write to the same address is read-first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (clears dout and every word)
//   we    : write din to mem[addr] on this edge
//   addr  : word address for read and write
//   din   : write data
//   dout  : registered read data, mem[addr] as it was before this edge
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] w_word [DEPTH];
  logic [DEPTH-1:0]      w_word_we;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_dout;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    assign w_word_we[g] = we && (addr == ADDR_WIDTH'(g));

    sync_ram_word #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_word (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_we    (w_word_we[g]),
      .i_din   (din),
      .o_q     (w_word[g])
    );
  end

  // The mux sees the word contents before this edge's write lands, which is
  // what makes a same-address read-during-write return the old data.
  assign w_rd_data = w_word[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_rd_data;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;

  // Behavioural model: an array of words and the value dout must hold.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_dout = '0;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  sync_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_dout = '0;
  endtask

  // One clock: drive inputs on the falling edge, then apply the spec rules
  // to the model at the rising edge (read old word, then write).
  task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = w;
    addr = a;
    din = d;
    @(posedge clk);
    if (rst_n) begin
      exp_dout = mem_m[a];
      if (w) mem_m[a] = d;
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic read_expect(input string name, input logic [AW-1:0] a, input logic [DW-1:0] v);
    cycle(1'b0, a, '0);
    #1 check(name, dout, v);
  endtask

  // Reset asserted mid-cycle with a write pending; the edge it covers is lost.
  task automatic reset_mid(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = w;
    addr = a;
    din = d;
    #2 rst_n = 1'b0;
    model_clear();
    #1 check("reset_immediate", dout, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    we = 1'b0;
  endtask

  // Compare process: dout must match the model on every falling edge.
  initial begin
    @(negedge clk);
    while (!done) begin
      check("dout_vs_model", dout, exp_dout);
      @(negedge clk);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    #1 rst_n = 1'b0;
    #1 check("reset_initial", dout, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Test 1: reset clears everything
    reset_mid(1'b1, 4'h7, 8'h99);
    for (int i = 0; i < DEPTH; i++) read_expect("read_after_reset", AW'(i), 8'h00);

    // Test 2: write sequence then readback
    write_word(4'h1, 8'hAA);
    write_word(4'h2, 8'hBB);
    write_word(4'h3, 8'hCC);
    read_expect("t2_read_1", 4'h1, 8'hAA);
    read_expect("t2_read_2", 4'h2, 8'hBB);
    read_expect("t2_read_3", 4'h3, 8'hCC);
    check("model_pin_mem2", mem_m[2], 8'hBB);

    // Test 6: hold address with we low
    for (int i = 0; i < 5; i++) read_expect("t6_hold", 4'h3, 8'hCC);

    // Test 3: read-first collision
    write_word(4'h5, 8'h11);
    write_word(4'h5, 8'h22);
    #1 check("t3_read_first", dout, 8'h11);
    read_expect("t3_new_data", 4'h5, 8'h22);

    // Test 4: boundaries and isolation
    write_word(4'h0, 8'h7E);
    write_word(4'hF, 8'h81);
    read_expect("t4_addr0", 4'h0, 8'h7E);
    read_expect("t4_addrF", 4'hF, 8'h81);
    read_expect("t4_addr1", 4'h1, 8'hAA);

    // Test 5: reset during a write
    reset_mid(1'b1, 4'h2, 8'h55);
    read_expect("t5_addr2", 4'h2, 8'h00);
    read_expect("t5_addr1", 4'h1, 8'h00);
    check("model_pin_cleared", mem_m[1], 8'h00);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_mid(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end else begin
        cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end
    end

    // Sweep the array so every word is compared at the end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, AW'(i), '0);
    @(negedge clk);
    done = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
